// File: rtl/axi4_rd_resp_seq_pkg.sv
// Shared constants, FSM states and the 4 KB boundary helper for the AXI4 read response sequencer.
// The ERR state and boundary helper exist only when AXI4_RD_SEQ_BOUNDARY_CHK_EN is defined.
package axi4_rd_resp_seq_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef AXI4_RD_SEQ_BOUNDARY_CHK_EN
        ST_ERR   = 2'd2,
`endif
        ST_BURST = 2'd1
    } state_t;

`ifdef AXI4_RD_SEQ_BOUNDARY_CHK_EN
    // Start offset plus burst byte count, evaluated in 13 bits, must not pass the 4 KB page end.
    function automatic logic crosses_4k(input logic [11:0] addr, input logic [7:0] len,
                                        input logic [2:0] size);
        logic [15:0] bytes;
        logic [12:0] sum;
        bytes = (16'(len) + 16'd1) << size;
        sum   = 13'(16'(addr) + bytes);
        return (sum > 13'd4096);
    endfunction
`endif

endpackage

// File: rtl/axi4_rd_resp_seq_if.sv
// Bundles the request FIFO, data FIFO and R-channel signals of the read response sequencer.
// slave is the sequencer's view; master is the surrounding FIFOs/fabric view.
interface axi4_rd_resp_seq_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              req_empty_n;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_len;
    logic [2:0]        req_size;
    logic [1:0]        req_burst;
    logic              req_deq;
    logic              dat_empty_n;
    logic [DATA_W-1:0] dat_d_in;
    logic              dat_deq;
    logic              r_valid;
    logic              r_ready;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              busy;

    modport slave (
        input  req_empty_n, req_id, req_addr, req_len, req_size, req_burst,
        output req_deq,
        input  dat_empty_n, dat_d_in,
        output dat_deq,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready,
        output busy
    );

    modport master (
        output req_empty_n, req_id, req_addr, req_len, req_size, req_burst,
        input  req_deq,
        output dat_empty_n, dat_d_in,
        input  dat_deq,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready,
        input  busy
    );

endinterface

// File: rtl/axi4_rd_resp_seq_outreg.sv
// R-channel output register: loads a beat when told to, holds it stable until the fabric accepts it.
module axi4_rd_seq_outreg #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [ID_W-1:0]   i_id,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_resp,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ID_W-1:0]   o_id,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_resp,
    output logic              o_last
);

    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    // A load only arrives when the register is empty or being drained, so it always wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_resp  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_id    <= i_id;
            r_data  <= i_data;
            r_resp  <= i_resp;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_id    = r_id;
    assign o_data  = r_data;
    assign o_resp  = r_resp;
    assign o_last  = r_last;

endmodule

// File: rtl/axi4_rd_resp_seq.sv
// AXI4 read response sequencer: drains request/data FIFOs into registered R-channel beats.
// Define AXI4_RD_SEQ_BOUNDARY_CHK_EN to answer 4 KB-crossing INCR bursts with SLVERR beats.
module axi4_rd_resp_seq
    import axi4_rd_resp_seq_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    axi4_rd_resp_seq_if.slave    bus
);

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic [7:0]        r_beat_cnt;
    logic              w_rvalid;
    logic              w_slot;
    logic              w_last;
    logic              w_req_pop;
    logic              w_dat_pop;
    logic              w_load;
    logic [DATA_W-1:0] w_ldata;
    logic [1:0]        w_lresp;
    logic [ADDR_W-1:0] w_unused_addr;
    logic              w_unused;

    assign w_unused_addr = bus.req_addr;
    assign w_unused      = ^{bus.req_size, bus.req_burst};

    assign w_slot = !w_rvalid || bus.r_ready;
    assign w_last = (r_beat_cnt == r_len);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_req_pop = 1'b0;
        w_dat_pop = 1'b0;
        w_load    = 1'b0;
        w_ldata   = bus.dat_d_in;
        w_lresp   = RESP_OKAY;
        case (r_state)
            ST_IDLE: begin
                w_req_pop = bus.req_empty_n;
                if (w_req_pop) begin
                    w_next = ST_BURST;
`ifdef AXI4_RD_SEQ_BOUNDARY_CHK_EN
                    if (bus.req_burst == BURST_INCR &&
                        crosses_4k(bus.req_addr[11:0], bus.req_len, bus.req_size))
                        w_next = ST_ERR;
`endif
                end
            end
            ST_BURST: begin
                w_dat_pop = bus.dat_empty_n && w_slot;
                w_load    = w_dat_pop;
                if (w_dat_pop && w_last) w_next = ST_IDLE;
            end
`ifdef AXI4_RD_SEQ_BOUNDARY_CHK_EN
            // Error beats are synthesised locally; the data FIFO is left untouched.
            ST_ERR: begin
                w_load  = w_slot;
                w_ldata = '0;
                w_lresp = RESP_SLVERR;
                if (w_load && w_last) w_next = ST_IDLE;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    // beat_cnt stops at LEN so a 256-beat burst never wraps the 8-bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id       <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else if (w_req_pop) begin
            r_id       <= bus.req_id;
            r_len      <= bus.req_len;
            r_beat_cnt <= '0;
        end else if (w_load && !w_last) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    axi4_rd_seq_outreg #(.ID_W(ID_W), .DATA_W(DATA_W)) u_outreg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_id    (r_id),
        .i_data  (w_ldata),
        .i_resp  (w_lresp),
        .i_last  (w_last),
        .i_ready (bus.r_ready),
        .o_valid (w_rvalid),
        .o_id    (bus.r_id),
        .o_data  (bus.r_data),
        .o_resp  (bus.r_resp),
        .o_last  (bus.r_last)
    );

    assign bus.req_deq = w_req_pop && i_rst_n;
    assign bus.dat_deq = w_dat_pop && i_rst_n;
    assign bus.r_valid = w_rvalid;
    assign bus.busy    = (r_state != ST_IDLE) || w_rvalid;

endmodule

// File: tb/tb_axi4_rd_resp_seq.sv
// Directed bench for axi4_rd_resp_seq: queue-backed request/data FIFOs and a beat scoreboard.
// Expected beats follow AXI4_RD_SEQ_BOUNDARY_CHK_EN when that macro is defined.
module tb_axi4_rd_resp_seq;
    import axi4_rd_resp_seq_pkg::*;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_rd_resp_seq_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi4_rd_resp_seq #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    req_t              rq[$];
    logic [DATA_W-1:0] dq[$];
    logic [71:0]       exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int deq_cnt, beats_got, pop_cyc, first_vld, acc_first, acc_last;
    bit s_req_deq, s_dat_deq, prev_stall, ready_mode;
    logic [71:0] prev, cur, expv;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_heads();
        bus.req_empty_n = (rq.size() != 0);
        if (rq.size() != 0) begin
            bus.req_id    = rq[0].id;
            bus.req_addr  = rq[0].addr;
            bus.req_len   = rq[0].len;
            bus.req_size  = rq[0].size;
            bus.req_burst = rq[0].burst;
        end
        bus.dat_empty_n = (dq.size() != 0);
        bus.dat_d_in    = (dq.size() != 0) ? dq[0] : '0;
    endtask

    task automatic push_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        req_t r;
        r.id = id; r.addr = addr; r.len = len; r.size = size; r.burst = burst;
        rq.push_back(r);
        drive_heads();
    endtask

    task automatic push_data(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) dq.push_back(base + 64'(i));
        drive_heads();
    endtask

    task automatic exp_beat(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp,
                            input logic last);
        exp_q.push_back({1'b1, id, data, resp, last});
    endtask

    task automatic start_test();
        exp_q.delete();
        deq_cnt = 0; beats_got = 0; pop_cyc = -1; first_vld = -1; acc_first = -1; acc_last = -1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy || rq.size() != 0) && n < 3000) begin
            @(negedge clk); #2;
            n++;
        end
        chk({tag, "_done"}, 96'(n < 3000), 96'(1));
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beats_got < target && n < 1000) begin
            @(negedge clk); #2;
            n++;
        end
        chk("wait_beats", 96'(beats_got >= target), 96'(1));
        @(posedge clk); #2;
    endtask

    task automatic end_test(input string tag, input int exp_deq, input int exp_beats);
        chk({tag, "_deq"}, 96'(deq_cnt), 96'(exp_deq));
        chk({tag, "_beats"}, 96'(beats_got), 96'(exp_beats));
        chk({tag, "_busy"}, 96'(bus.busy), 96'(0));
        @(posedge clk); #2;
    endtask

    // Pop modelled FIFOs on the edge where the DUT dequeued, then present the next head.
    always @(posedge clk) begin
        #1;
        if (rst_n && s_req_deq && rq.size() > 0) void'(rq.pop_front());
        if (rst_n && s_dat_deq && dq.size() > 0) void'(dq.pop_front());
        bus.r_ready = ready_mode ? ~bus.r_ready : 1'b1;
        drive_heads();
    end

    always @(negedge clk) begin
        cyc++;
        s_req_deq = bus.req_deq;
        s_dat_deq = bus.dat_deq;
        cur = {bus.r_valid, bus.r_id, bus.r_data, bus.r_resp, bus.r_last};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (s_dat_deq) deq_cnt++;
            if (s_req_deq && pop_cyc < 0) pop_cyc = cyc;
            if (bus.r_valid && first_vld < 0) first_vld = cyc;
            if (prev_stall) chk("hold", 96'(cur), 96'(prev));
            if (bus.r_valid && bus.r_ready) begin
                beats_got++;
                if (acc_first < 0) acc_first = cyc;
                acc_last = cyc;
                if (exp_q.size() > 0) begin
                    expv = exp_q.pop_front();
                    chk("beat", 96'(cur), 96'(expv));
                end
            end
            prev_stall = bus.r_valid && !bus.r_ready;
            prev = cur;
        end
    end

    initial begin
        bus.r_ready = 1'b1;
        ready_mode  = 1'b0;
        drive_heads();
        start_test();

        // Reset: outputs cleared, pops suppressed although both FIFOs hold entries.
        push_data(1, 64'hA5);
        push_req(4'd3, 32'h0, 8'd0, 3'd3, BURST_INCR);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rvalid", 96'(bus.r_valid), 96'(0));
        chk("rst_fields", 96'({bus.r_id, bus.r_data, bus.r_resp, bus.r_last}), 96'(0));
        chk("rst_busy", 96'(bus.busy), 96'(0));
        chk("rst_deq", 96'({bus.req_deq, bus.dat_deq}), 96'(0));

        // T1: single beat, first R_VALID two cycles after the request pop.
        start_test();
        exp_beat(4'd3, 64'hA5, RESP_OKAY, 1'b1);
        rst_n = 1'b1;
        wait_done("t1");
        chk("t1_latency", 96'(first_vld - pop_cyc), 96'(2));
        end_test("t1", 1, 1);

        // T2: LEN=3 streaming; FIXED at 0xFFC would cross 4 KB as INCR but is never flagged.
        start_test();
        push_data(4, 64'h200);
        push_req(4'd5, 32'hFFC, 8'd3, 3'd2, BURST_FIXED);
        exp_beat(4'd5, 64'h200, RESP_OKAY, 1'b0);
        exp_beat(4'd5, 64'h201, RESP_OKAY, 1'b0);
        exp_beat(4'd5, 64'h202, RESP_OKAY, 1'b0);
        exp_beat(4'd5, 64'h203, RESP_OKAY, 1'b1);
        wait_done("t2");
        chk("t2_back2back", 96'(acc_last - acc_first), 96'(3));
        end_test("t2", 4, 4);

        // T3: LEN=7 WRAP with R_READY toggling every cycle.
        start_test();
        ready_mode = 1'b1;
        push_data(8, 64'h300);
        push_req(4'd6, 32'hFF8, 8'd7, 3'd3, BURST_WRAP);
        for (int i = 0; i < 8; i++) exp_beat(4'd6, 64'h300 + 64'(i), RESP_OKAY, i == 7);
        wait_done("t3");
        ready_mode = 1'b0;
        end_test("t3", 8, 8);

        // T4: data FIFO runs dry after beat 1 for five cycles.
        start_test();
        push_data(1, 64'h400);
        push_req(4'd7, 32'h40, 8'd3, 3'd3, BURST_INCR);
        for (int i = 0; i < 4; i++) exp_beat(4'd7, 64'h400 + 64'(i), RESP_OKAY, i == 3);
        wait_beats(1);
        repeat (5) @(posedge clk);
        #2;
        chk("t4_stall_beats", 96'(beats_got), 96'(1));
        push_data(3, 64'h401);
        wait_done("t4");
        end_test("t4", 4, 4);

        // T5: reset during a LEN=15 burst, then a fresh burst.
        start_test();
        push_data(16, 64'h500);
        push_req(4'd9, 32'h0, 8'd15, 3'd3, BURST_INCR);
        wait_beats(5);
        rst_n = 1'b0;
        #1;
        chk("t5_rvalid", 96'(bus.r_valid), 96'(0));
        chk("t5_busy", 96'(bus.busy), 96'(0));
        dq.delete();
        push_data(2, 64'h5A0);
        push_req(4'd10, 32'h100, 8'd1, 3'd3, BURST_INCR);
        #1;
        chk("t5_deq_in_rst", 96'({bus.req_deq, bus.dat_deq}), 96'(0));
        repeat (2) @(posedge clk);
        #2;
        start_test();
        exp_beat(4'd10, 64'h5A0, RESP_OKAY, 1'b0);
        exp_beat(4'd10, 64'h5A1, RESP_OKAY, 1'b1);
        rst_n = 1'b1;
        wait_done("t5");
        end_test("t5", 2, 2);

        // T6: INCR at 0xFF8 crosses the 4 KB page (4104 > 4096); 0xFF0 ends exactly on it.
        start_test();
        push_req(4'd11, 32'hFF8, 8'd1, 3'd3, BURST_INCR);
        push_req(4'd12, 32'hFF0, 8'd1, 3'd3, BURST_INCR);
`ifdef AXI4_RD_SEQ_BOUNDARY_CHK_EN
        push_data(2, 64'h600);
        exp_beat(4'd11, 64'h0, RESP_SLVERR, 1'b0);
        exp_beat(4'd11, 64'h0, RESP_SLVERR, 1'b1);
        exp_beat(4'd12, 64'h600, RESP_OKAY, 1'b0);
        exp_beat(4'd12, 64'h601, RESP_OKAY, 1'b1);
        wait_done("t6");
        end_test("t6", 2, 4);
`else
        push_data(4, 64'h600);
        exp_beat(4'd11, 64'h600, RESP_OKAY, 1'b0);
        exp_beat(4'd11, 64'h601, RESP_OKAY, 1'b1);
        exp_beat(4'd12, 64'h602, RESP_OKAY, 1'b0);
        exp_beat(4'd12, 64'h603, RESP_OKAY, 1'b1);
        wait_done("t6");
        end_test("t6", 4, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
